core_mem_responder: RTL and testbench

Memory-side responder for the core's fetch/load/store request pulses. It captures instruction and data requests, arbitrates them onto one single-port synchronous SRAM, and returns single-cycle `inst_valid`/`data_valid` response pulses with read data. It sits between the core and on-chip SRAM and replaces any testbench memory model in synthesizable builds.

---
 rtl/core_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_core_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_responder.sv
// Single-port SRAM responder for core fetch/load/store request pulses.
// Optional per-channel error outputs are enabled with `define CORE_MEM_RESP_ERR_EN.

module core_mem_responder #(
  parameter int ADDR_W      = 14,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_fetch,
  input  logic [31:0]       inst_addr,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  input  logic              load_data,
  input  logic              store_data,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wstrb,
  output logic              data_valid,
  output logic [31:0]       data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef CORE_MEM_RESP_ERR_EN
  ,
  output logic              inst_err,
  output logic              data_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic        sel_data_q, sel_data_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        inst_pend_q, inst_pend_d;
  logic        data_pend_q, data_pend_d;
  logic [29:0] inst_word_q;
  logic [29:0] data_word_q;
  logic        data_store_q;
  logic [31:0] data_wdata_q;
  logic [3:0]  data_wstrb_q;
  logic [31:0] inst_data_q;
  logic [31:0] data_rdata_q;

  logic        inst_take, data_take;
  logic        resp_inst, resp_data;
  logic [29:0] cur_word;
  logic        cur_oor, cur_store, rd_last;
  logic [31:0] rd_word;

  // Byte offsets never reach the SRAM; lanes are chosen by the core.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{inst_addr[1:0], data_addr[1:0]};

  assign inst_take   = inst_fetch && !inst_pend_q;
  assign data_take   = (load_data || store_data) && !data_pend_q;
  assign resp_inst   = (state_q == S_RESP) && !sel_data_q;
  assign resp_data   = (state_q == S_RESP) && sel_data_q;
  assign inst_pend_d = (inst_pend_q && !resp_inst) || inst_take;
  assign data_pend_d = (data_pend_q && !resp_data) || data_take;

  assign cur_word  = sel_data_q ? data_word_q : inst_word_q;
  assign cur_oor   = |(cur_word >> ADDR_W);
  assign cur_store = sel_data_q && data_store_q;
  assign rd_last   = (state_q == S_WAIT) && (cnt_q == 3'd0);
  assign rd_word   = cur_oor ? 32'd0 : mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_data_q <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      sel_data_q <= sel_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stores and out-of-range accesses take one fixed settle cycle in WAIT so
  // they always complete three cycles after the request.
  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    state_d    = state_q;
    sel_data_d = sel_data_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (inst_pend_d || data_pend_d) begin
          state_d    = S_ISSUE;
          sel_data_d = data_pend_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = (cur_store || cur_oor) ? 3'd0 : CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (state_q == S_ISSUE && !cur_oor) begin
      mem_en   = 1'b1;
      mem_addr = cur_word[ADDR_W-1:0];
      if (cur_store) begin
        mem_we    = data_wstrb_q;
        mem_wdata = data_wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      inst_word_q  <= 30'd0;
      data_word_q  <= 30'd0;
      data_store_q <= 1'b0;
      data_wdata_q <= 32'd0;
      data_wstrb_q <= 4'd0;
      inst_data_q  <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      inst_pend_q <= inst_pend_d;
      data_pend_q <= data_pend_d;
      if (inst_take) inst_word_q <= inst_addr[31:2];
      if (data_take) begin
        data_word_q  <= data_addr[31:2];
        data_store_q <= store_data;
        data_wdata_q <= data_wdata;
        data_wstrb_q <= data_wstrb;
      end
      if (rd_last && !cur_store) begin
        if (sel_data_q) data_rdata_q <= rd_word;
        else            inst_data_q  <= rd_word;
      end
    end
  end

  assign inst_valid = resp_inst;
  assign data_valid = resp_data;
  assign inst_data  = inst_data_q;
  assign data_rdata = data_rdata_q;

`ifdef CORE_MEM_RESP_ERR_EN
  assign inst_err = resp_inst && cur_oor;
  assign data_err = resp_data && cur_oor;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: directed protocol steps plus randomized
// fetch and store/load traffic checked against a word-array reference.

module tb_core_mem_responder;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              inst_fetch, load_data, store_data;
  logic [31:0]       inst_addr, data_addr, data_wdata;
  logic [3:0]        data_wstrb;
  logic              inst_valid, data_valid, mem_en;
  logic [31:0]       inst_data, data_rdata, mem_wdata, mem_rdata;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;

  logic              inst_fetch3;
  logic [31:0]       inst_addr3;
  logic              inst_valid3, mem_en3;
  logic [31:0]       inst_data3, mem_rdata3;
  logic [ADDR_W-1:0] mem_addr3;
  logic              unused_dv3;
  logic [31:0]       unused_dr3, unused_wd3;
  logic [3:0]        unused_we3;

`ifdef CORE_MEM_RESP_ERR_EN
  logic inst_err, data_err, unused_ie3, unused_de3;
`endif

  core_mem_responder #(.ADDR_W(ADDR_W), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst_data(inst_data),
    .load_data(load_data), .store_data(store_data),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_valid(data_valid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef CORE_MEM_RESP_ERR_EN
    , .inst_err(inst_err), .data_err(data_err)
`endif
  );

  core_mem_responder #(.ADDR_W(ADDR_W), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch3), .inst_addr(inst_addr3),
    .inst_valid(inst_valid3), .inst_data(inst_data3),
    .load_data(1'b0), .store_data(1'b0),
    .data_addr(32'd0), .data_wdata(32'd0), .data_wstrb(4'd0),
    .data_valid(unused_dv3), .data_rdata(unused_dr3),
    .mem_en(mem_en3), .mem_we(unused_we3), .mem_addr(mem_addr3),
    .mem_wdata(unused_wd3), .mem_rdata(mem_rdata3)
`ifdef CORE_MEM_RESP_ERR_EN
    , .inst_err(unused_ie3), .data_err(unused_de3)
`endif
  );

  // SRAM array shared by both responders; dut3 only ever reads it.
  logic [31:0]       sram [0:DEPTH-1] = '{default: '0};
  logic [31:0]       rd1_q, p3_0, p3_1, p3_2;
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr;
  logic [31:0]       bd_data;

  always @(posedge clk) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      rd1_q <= sram[mem_addr];
    end
    p3_0 <= mem_en3 ? sram[mem_addr3] : 32'hBAD0_BAD0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign mem_rdata  = rd1_q;
  assign mem_rdata3 = p3_2;

  // Reference: contents the SRAM must hold, from request semantics alone.
  logic [31:0] golden [0:DEPTH-1] = '{default: '0};

  int total = 0;
  int bad   = 0;
  int iv_count = 0;
  always @(negedge clk) if (inst_valid) iv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = ADDR_W'(a);
    bd_data = d;
    golden[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Observation window; cycle 0 is the cycle the request pulses are driven.
  int          w_inst_first, w_inst_cnt, w_data_first, w_data_cnt, w_men_first, w_men_cnt;
  bit          w_both, w_derr;
  logic [31:0] w_inst_data, w_data_rdata, w_mwdata;
  logic [ADDR_W-1:0] w_maddr;
  logic [3:0]  w_mwe;

  task automatic run_window(input int n, input bit use3, input int rst_at);
    w_inst_first = -1; w_data_first = -1; w_men_first = -1;
    w_inst_cnt = 0; w_data_cnt = 0; w_men_cnt = 0;
    w_both = 1'b0; w_derr = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (use3 ? inst_valid3 : inst_valid) begin
        if (w_inst_first < 0) w_inst_first = c;
        w_inst_cnt++;
        w_inst_data = use3 ? inst_data3 : inst_data;
      end
      if (!use3 && data_valid) begin
        if (w_data_first < 0) w_data_first = c;
        w_data_cnt++;
        w_data_rdata = data_rdata;
`ifdef CORE_MEM_RESP_ERR_EN
        w_derr = data_err;
`endif
      end
      if (use3 ? mem_en3 : mem_en) begin
        if (w_men_first < 0) begin
          w_men_first = c;
          w_maddr  = use3 ? mem_addr3 : mem_addr;
          w_mwe    = use3 ? 4'd0 : mem_we;
          w_mwdata = use3 ? 32'd0 : mem_wdata;
        end
        w_men_cnt++;
      end
      if (inst_valid && data_valid) w_both = 1'b1;
      @(posedge clk); #1;
      inst_fetch = 1'b0; inst_fetch3 = 1'b0; load_data = 1'b0; store_data = 1'b0;
      rst = (c + 1 == rst_at);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          addrs [100];
    int          a, base, lat;
    bit          found;
    logic [31:0] got, wd, ba;
    logic [3:0]  st;

    rst = 1'b1;
    inst_fetch = 1'b0; load_data = 1'b0; store_data = 1'b0;
    inst_addr = 32'd0; data_addr = 32'd0; data_wdata = 32'd0; data_wstrb = 4'd0;
    inst_fetch3 = 1'b0; inst_addr3 = 32'd0;

    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
`ifdef CORE_MEM_RESP_ERR_EN
    check("rst_inst_err", 32'(inst_err), 0);
    check("rst_data_err", 32'(data_err), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    bd_write(4, 32'h0000_0013);

    // Fetch from word 4.
    inst_fetch = 1'b1; inst_addr = 32'h0000_0010;
    run_window(8, 1'b0, -1);
    check("f_men_cycle", w_men_first, 1);
    check("f_men_addr", 32'(w_maddr), 4);
    check("f_men_we", 32'(w_mwe), 0);
    check("f_valid_cycle", w_inst_first, 3);
    check("f_valid_cnt", w_inst_cnt, 1);
    check("f_data", w_inst_data, 32'h0000_0013);
    check("f_no_data_valid", w_data_cnt, 0);

    // Partial store then load back.
    store_data = 1'b1; data_addr = 32'h20; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    golden[8] = merge(golden[8], 32'hDEAD_BEEF, 4'b0011);
    run_window(8, 1'b0, -1);
    check("s_men_cycle", w_men_first, 1);
    check("s_men_addr", 32'(w_maddr), 8);
    check("s_men_we", 32'(w_mwe), 32'b0011);
    check("s_men_wdata", w_mwdata, 32'hDEAD_BEEF);
    check("s_valid_cycle", w_data_first, 3);
    check("s_valid_cnt", w_data_cnt, 1);
    load_data = 1'b1; data_addr = 32'h20;
    run_window(8, 1'b0, -1);
    check("l_valid_cycle", w_data_first, 3);
    check("l_rdata", w_data_rdata, 32'h0000_BEEF);
    check("l_rdata_ref", w_data_rdata, golden[8]);

    // Simultaneous load and fetch: data first, never both valids together.
    load_data = 1'b1; data_addr = 32'h20; inst_fetch = 1'b1; inst_addr = 32'h10;
    run_window(10, 1'b0, -1);
    check("arb_data_cycle", w_data_first, 3);
    check("arb_inst_cycle", w_inst_first, 6);
    check("arb_both", 32'(w_both), 0);
    check("arb_data_cnt", w_data_cnt, 1);
    check("arb_inst_cnt", w_inst_cnt, 1);
    check("arb_rdata", w_data_rdata, golden[8]);
    check("arb_idata", w_inst_data, golden[4]);

    // Out-of-range load and store.
    load_data = 1'b1; data_addr = 32'h0001_0000;
    run_window(8, 1'b0, -1);
    check("oor_l_men", w_men_cnt, 0);
    check("oor_l_cycle", w_data_first, 3);
    check("oor_l_rdata", w_data_rdata, 0);
`ifdef CORE_MEM_RESP_ERR_EN
    check("oor_l_err", 32'(w_derr), 1);
`endif
    store_data = 1'b1; data_addr = 32'h0001_0020; data_wdata = 32'hFFFF_FFFF; data_wstrb = 4'hF;
    run_window(8, 1'b0, -1);
    check("oor_s_men", w_men_cnt, 0);
    check("oor_s_cycle", w_data_first, 3);
`ifdef CORE_MEM_RESP_ERR_EN
    check("oor_s_err", 32'(w_derr), 1);
`endif
    load_data = 1'b1; data_addr = 32'h20;
    run_window(8, 1'b0, -1);
    check("oor_s_dropped", w_data_rdata, golden[8]);
`ifdef CORE_MEM_RESP_ERR_EN
    check("inrange_err", 32'(w_derr), 0);
`endif

    // Three-cycle SRAM: latency, reset mid-access, recovery.
    inst_fetch3 = 1'b1; inst_addr3 = 32'h10;
    run_window(9, 1'b1, -1);
    check("l3_men_cycle", w_men_first, 1);
    check("l3_men_addr", 32'(w_maddr), 4);
    check("l3_valid_cycle", w_inst_first, 5);
    check("l3_valid_cnt", w_inst_cnt, 1);
    check("l3_data", w_inst_data, golden[4]);
    inst_fetch3 = 1'b1; inst_addr3 = 32'h20;
    run_window(9, 1'b1, 2);
    check("l3_rst_no_valid", w_inst_cnt, 0);
    check("l3_rst_data", inst_data3, 0);
    inst_fetch3 = 1'b1; inst_addr3 = 32'h22;
    run_window(9, 1'b1, -1);
    check("l3_after_rst_cycle", w_inst_first, 5);
    check("l3_after_rst_data", w_inst_data, golden[8]);

    // Random back-to-back fetches.
    for (int i = 0; i < 100; i++) begin
      addrs[i] = int'($urandom_range(0, DEPTH - 1));
      bd_write(addrs[i], $urandom);
    end
    base = iv_count;
    for (int i = 0; i < 100; i++) begin
      inst_fetch = 1'b1;
      inst_addr  = (32'(addrs[i]) << 2) | 32'($urandom_range(0, 3));
      found = 1'b0; lat = 0; got = 32'd0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        if (inst_valid) begin found = 1'b1; lat = t; got = inst_data; end
        @(posedge clk); #1;
        inst_fetch = 1'b0;
      end
      check("rnd_f_seen", 32'(found), 1);
      check("rnd_f_latency", lat, 3);
      check("rnd_f_data", got, golden[addrs[i]]);
    end
    repeat (4) begin @(posedge clk); #1; end
    check("rnd_f_pulses", iv_count - base, 100);

    // Random partial stores each followed by a load of the same word.
    for (int i = 0; i < 20; i++) begin
      a  = int'($urandom_range(0, DEPTH - 1));
      ba = (32'(a) << 2) | 32'($urandom_range(0, 3));
      wd = $urandom;
      st = 4'($urandom_range(1, 15));
      store_data = 1'b1; data_addr = ba; data_wdata = wd; data_wstrb = st;
      golden[a] = merge(golden[a], wd, st);
      run_window(8, 1'b0, -1);
      check("rnd_s_cycle", w_data_first, 3);
      check("rnd_s_addr", 32'(w_maddr), 32'(a));
      check("rnd_s_we", 32'(w_mwe), 32'(st));
      load_data = 1'b1; data_addr = ba;
      run_window(8, 1'b0, -1);
      check("rnd_l_cycle", w_data_first, 3);
      check("rnd_l_men", w_men_cnt, 1);
      check("rnd_l_data", w_data_rdata, golden[a]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
